// File: rtl/serializador_16b_pkg.sv
// Shared definitions for the serializador_16b parallel-to-serial transmitter.
//   estado_t       : FSM state encoding (OCIOSO, ENVIANDO, PARIDADE, FIM)
//   LARGURA_PADRAO : default data word width
package serializador_16b_pkg;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    ENVIANDO = 2'd1,
    PARIDADE = 2'd2,
    FIM      = 2'd3
  } estado_t;

  localparam int LARGURA_PADRAO = 16;

endpackage

// File: rtl/serializador_16b_shifter_piso.sv
// Parallel-in / serial-out shift register, MSB first.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   carga        : load dado into the register (has priority over desloca)
//   desloca      : shift left by one, 0 enters the LSB
//   dado         : parallel word to load
//   msb          : current MSB of the register (the serial bit)
module serializador_16b_shifter_piso
  import serializador_16b_pkg::*;
#(
  parameter int LARGURA = LARGURA_PADRAO
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               carga,
  input  logic               desloca,
  input  logic [LARGURA-1:0] dado,
  output logic               msb
);

  logic [LARGURA-1:0] shreg_q, shreg_d;

  always_comb begin
    shreg_d = shreg_q;
    if (carga)
      shreg_d = dado;
    else if (desloca)
      shreg_d = {shreg_q[LARGURA-2:0], 1'b0};
  end

  always_ff @(posedge clock) begin
    if (reset) shreg_q <= '0;
    else       shreg_q <= shreg_d;
  end

  assign msb = shreg_q[LARGURA-1];

endmodule

// File: rtl/serializador_16b.sv
// Parallel-to-serial transmitter. Accepts a LARGURA-bit word on a valid/ready
// handshake and shifts it out MSB first, one bit per clock, followed by a
// one-cycle fim pulse.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   valor        : word to transmit, sampled only on accept
//   valido       : requester has a word on valor
//   pronto       : block can accept a word this cycle
//   serial       : serial data bit (0 outside a frame)
//   ativo        : high on every cycle serial carries a frame bit
//   fim          : one-cycle pulse on the cycle after the last frame bit
// Optional macro SERIALIZADOR_PARITY_EN appends an even-parity bit (XOR of
// the accepted word) as an extra frame bit after the data bits.
module serializador_16b
  import serializador_16b_pkg::*;
#(
  parameter int LARGURA = LARGURA_PADRAO
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [LARGURA-1:0] valor,
  input  logic               valido,
  output logic               pronto,
  output logic               serial,
  output logic               ativo,
  output logic               fim
);

  localparam int CONT_W = $clog2(LARGURA + 1);

  estado_t           estado_q, estado_d;
  logic [CONT_W-1:0] cont_q, cont_d;
  logic              carga, desloca, msb;

`ifdef SERIALIZADOR_PARITY_EN
  // Parity is taken from valor at accept so valor may change afterwards.
  logic par_q, par_d;

  always_comb begin
    par_d = par_q;
    if (carga) par_d = ^valor;
  end

  always_ff @(posedge clock) begin
    if (reset) par_q <= 1'b0;
    else       par_q <= par_d;
  end
`endif

  serializador_16b_shifter_piso #(.LARGURA(LARGURA)) u_piso (
    .clock   (clock),
    .reset   (reset),
    .carga   (carga),
    .desloca (desloca),
    .dado    (valor),
    .msb     (msb)
  );

  // Outputs decode from state and the shift register only; valido/valor only
  // steer the next state, so there is no combinational path to any output.
  always_comb begin
    estado_d = estado_q;
    cont_d   = cont_q;
    carga    = 1'b0;
    desloca  = 1'b0;
    pronto   = 1'b0;
    ativo    = 1'b0;
    serial   = 1'b0;
    fim      = 1'b0;
    case (estado_q)
      OCIOSO: begin
        pronto = 1'b1;
        if (valido) begin
          carga    = 1'b1;
          cont_d   = CONT_W'(LARGURA - 1);
          estado_d = ENVIANDO;
        end
      end
      ENVIANDO: begin
        ativo   = 1'b1;
        serial  = msb;
        desloca = 1'b1;
        if (cont_q == '0) begin
`ifdef SERIALIZADOR_PARITY_EN
          estado_d = PARIDADE;
`else
          estado_d = FIM;
`endif
        end else begin
          cont_d = cont_q - CONT_W'(1);
        end
      end
`ifdef SERIALIZADOR_PARITY_EN
      PARIDADE: begin
        ativo    = 1'b1;
        serial   = par_q;
        estado_d = FIM;
      end
`endif
      FIM: begin
        fim      = 1'b1;
        estado_d = OCIOSO;
      end
      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= OCIOSO;
      cont_q   <= '0;
    end else begin
      estado_q <= estado_d;
      cont_q   <= cont_d;
    end
  end

endmodule
